// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM encodings shared by the
// alu_seq datapath and anything that decodes its results.
package alu_pkg;

    // Opcodes presented on the op port
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_CLAMP = 4'd5;
    localparam logic [3:0] OP_SEED  = 4'd6;
    localparam logic [3:0] OP_RNG   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;

    // Bit positions inside the 3-bit flags word {carry, overflow, zero}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_W     = 3;

    // Control FSM encodings
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    // Assemble a flags word from its named fields so bit positions live in one place
    function automatic logic [FLAG_W-1:0] make_flags(
        input logic carry,
        input logic ovf,
        input logic zero
    );
        logic [FLAG_W-1:0] f;
        f             = '0;
        f[FLAG_CARRY] = carry;
        f[FLAG_OVF]   = ovf;
        f[FLAG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_lfsr.sv
// alu_lfsr: free-running right-shifting Galois LFSR with a synchronous load.
// A load of zero is replaced by 1 so the register can never lock up at all-zero.
module alu_lfsr
    import alu_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] load_next;

    // Each bit takes its upper neighbour, xored with the tap when the outgoing bit is set
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign step_next[gi] = state_reg[gi+1] ^ (state_reg[0] & LFSR_TAPS[gi]);
        end
    endgenerate
    assign step_next[WIDTH-1] = state_reg[0] & LFSR_TAPS[WIDTH-1];

    // Zero seed would freeze the sequence, so it maps to 1
    assign load_next = (load_val == '0) ? WIDTH'(1) : load_val;

    // Register: reset to 1, load on SEED, otherwise advance every cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= WIDTH'(1);
        end else if (load) begin
            state_reg <= load_next;
        end else begin
            state_reg <= step_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU between decode and writeback. Single-cycle ops
// complete on the accept edge; MUL runs a WIDTH-step shift-add sequence
// during which the input side is stalled. Results are held under backpressure.
module alu_seq
    import alu_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [2:0]        flags
);

    localparam int CNT_W = $clog2(WIDTH);

    // Control and output registers
    logic [0:0]         state_reg,     state_next;
    logic               out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]   result_reg,    result_next;
    logic [FLAG_W-1:0]  flags_reg,     flags_next;

    // Multiplier working registers
    logic [CNT_W-1:0]   cnt_reg,       cnt_next;
    logic [2*WIDTH-1:0] mcand_reg,     mcand_next;
    logic [WIDTH-1:0]   mplier_reg,    mplier_next;
    logic [2*WIDTH-1:0] prod_reg,      prod_next;

    logic               accept;
    logic               seed_load;
    logic [WIDTH-1:0]   lfsr_state;

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   alu_result;
    logic [FLAG_W-1:0]  alu_flags;

    logic [2*WIDTH-1:0] prod_step;
    logic               mul_last;

    // Handshake: only the idle FSM with a free (or draining) output slot takes work
    assign in_ready  = reset_n && (state_reg == S_IDLE) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign seed_load = accept && (op == OP_SEED);

    alu_lfsr #(
        .WIDTH     (WIDTH),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (seed_load),
        .load_val (a),
        .state    (lfsr_state)
    );

    // Widened add/sub so the top bit is carry-out / borrow
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};

    // Single-cycle result and flags; reserved opcodes report all-zero flags
    always_comb begin
        logic carry;
        logic ovf;
        logic zero_en;
        alu_result = '0;
        carry      = 1'b0;
        ovf        = 1'b0;
        zero_en    = 1'b1;
        case (op)
            OP_ADD: begin
                alu_result = add_full[WIDTH-1:0];
                carry      = add_full[WIDTH];
                ovf        = (a[WIDTH-1] == b[WIDTH-1]) &&
                             (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = sub_full[WIDTH-1:0];
                carry      = ~sub_full[WIDTH];
            end
            OP_AND:   alu_result = a & b;
            OP_OR:    alu_result = a | b;
            OP_XOR:   alu_result = a ^ b;
            OP_CLAMP: alu_result = (a < b) ? a : b;
            OP_SEED:  alu_result = a;
            // RNG reports the value held during the accept cycle, before this edge's advance
            OP_RNG:   alu_result = lfsr_state;
            default: begin
                alu_result = '0;
                zero_en    = 1'b0;
            end
        endcase
        alu_flags = make_flags(carry, ovf, zero_en && (alu_result == '0));
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    assign prod_step = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_last  = (cnt_reg == CNT_W'(WIDTH - 1));

    // Next-state logic for the FSM, multiplier and output slot
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        prod_next      = prod_reg;
        result_next    = result_reg;
        flags_next     = flags_reg;
        // Output slot drains on out_ready unless refilled below
        out_valid_next = out_valid_reg && !out_ready;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_next  = S_MUL;
                        cnt_next    = '0;
                        mcand_next  = {{WIDTH{1'b0}}, a};
                        mplier_next = b;
                        prod_next   = '0;
                    end else begin
                        result_next    = alu_result;
                        flags_next     = alu_flags;
                        out_valid_next = 1'b1;
                    end
                end
            end
            S_MUL: begin
                prod_next   = prod_step;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CNT_W'(1);
                // Output slot is always empty here: MUL was only accepted with a draining slot
                if (mul_last) begin
                    state_next     = S_IDLE;
                    result_next    = prod_step[WIDTH-1:0];
                    flags_next     = make_flags(|prod_step[2*WIDTH-1:WIDTH], 1'b0,
                                                prod_step[WIDTH-1:0] == '0);
                    out_valid_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register; reset also discards any multiply in progress
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            flags_reg     <= '0;
            cnt_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            prod_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            flags_reg     <= flags_next;
            cnt_reg       <= cnt_next;
            mcand_reg     <= mcand_next;
            mplier_reg    <= mplier_next;
            prod_reg      <= prod_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, directed multi-cycle sequences and random traffic
// for alu_seq at WIDTH=16, all checked against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [2:0]    flags;

    alu_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Reference model state
    logic [W-1:0] m_lfsr;
    logic [W-1:0] m_res;
    logic [2:0]   m_flg;
    bit           m_ov;
    int           mul_left;
    logic [18:0]  mul_exp;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [2:0]   flg;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Returns {carry, overflow, zero, result} from plain integer arithmetic
    function automatic logic [18:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W-1:0] rng);
        longint unsigned p;
        int sx, sy, ss;
        logic [W-1:0] r;
        logic c, v;
        r = '0; c = 1'b0; v = 1'b0;
        case (o)
            OP_ADD: begin
                p  = longint'(x) + longint'(y);
                r  = p[15:0];
                c  = (p > 65535);
                sx = $signed(x);
                sy = $signed(y);
                ss = sx + sy;
                v  = (ss > 32767) || (ss < -32768);
            end
            OP_SUB:   begin r = x - y; c = (x >= y); end
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_XOR:   r = x ^ y;
            OP_CLAMP: r = (x < y) ? x : y;
            OP_SEED:  r = x;
            OP_RNG:   r = rng;
            OP_MUL: begin
                p = longint'(x) * longint'(y);
                r = p[15:0];
                c = (p > 65535);
            end
            default: return 19'h0;
        endcase
        return {c, v, (r == 0), r};
    endfunction

    function automatic bit m_ready();
        return reset_n && (mul_left == 0) && (!m_ov || out_ready);
    endfunction

    // One clock: check outputs against the model, take the edge, update the model
    task automatic tick();
        bit           acc, rdy_o, rst_o;
        logic [3:0]   op_s;
        logic [W-1:0] a_s;
        logic [18:0]  e;
        #1;
        if (chk_on) begin
            chk("out_valid", out_valid, m_ov);
            chk("in_ready", in_ready, m_ready());
            if (m_ov) begin
                chk("result", result, m_res);
                chk("flags", flags, m_flg);
            end
        end
        acc   = in_valid && m_ready();
        rdy_o = out_ready;
        rst_o = reset_n;
        op_s  = op;
        a_s   = a;
        e     = model(op, a, b, m_lfsr);
        if (acc) $display("txn op=%0d a=%h b=%h expect res=%h flags=%b", op, a, b, e[15:0], e[18:16]);
        @(posedge clk);
        if (!rst_o) begin
            m_lfsr   = 16'h0001;
            m_ov     = 1'b0;
            mul_left = 0;
            m_res    = '0;
            m_flg    = '0;
        end else begin
            if (acc && op_s != OP_MUL) begin
                {m_flg, m_res} = e;
                m_ov = 1'b1;
            end else if (mul_left == 1) begin
                {m_flg, m_res} = mul_exp;
                m_ov = 1'b1;
            end else if (rdy_o) begin
                m_ov = 1'b0;
            end
            if (acc && op_s == OP_MUL) begin
                mul_left = W;
                mul_exp  = e;
            end else if (mul_left > 0) begin
                mul_left--;
            end
            m_lfsr = (acc && op_s == OP_SEED) ? ((a_s == 0) ? 16'h0001 : a_s) : lfsr_step(m_lfsr);
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;

        // Vector table: back-to-back single-cycle ops, including the SEED/RNG walk
        vecs[0]  = '{OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 3'b101};
        vecs[1]  = '{OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 3'b010};
        vecs[2]  = '{OP_SUB,   16'd5,    16'd5,    16'h0000, 3'b101};
        vecs[3]  = '{OP_SUB,   16'd3,    16'd5,    16'hFFFE, 3'b000};
        vecs[4]  = '{OP_AND,   16'hF0F0, 16'hFF00, 16'hF000, 3'b000};
        vecs[5]  = '{OP_OR,    16'h00F0, 16'h0F00, 16'h0FF0, 3'b000};
        vecs[6]  = '{OP_XOR,   16'hAAAA, 16'hAAAA, 16'h0000, 3'b001};
        vecs[7]  = '{OP_CLAMP, 16'd1000, 16'd255,  16'd255,  3'b000};
        vecs[8]  = '{OP_CLAMP, 16'd12,   16'd255,  16'd12,   3'b000};
        vecs[9]  = '{OP_CLAMP, 16'd0,    16'd5,    16'd0,    3'b001};
        vecs[10] = '{OP_ADD,   16'h8000, 16'h8000, 16'h0000, 3'b111};
        vecs[11] = '{4'd9,     16'd5,    16'd6,    16'h0000, 3'b000};
        vecs[12] = '{4'd15,    16'hFFFF, 16'hFFFF, 16'h0000, 3'b000};
        vecs[13] = '{OP_SEED,  16'd12,   16'd0,    16'h000C, 3'b000};
        vecs[14] = '{OP_RNG,   16'd0,    16'd0,    16'h000C, 3'b000};
        vecs[15] = '{OP_RNG,   16'd0,    16'd0,    16'h0006, 3'b000};
        vecs[16] = '{OP_RNG,   16'd0,    16'd0,    16'h0003, 3'b000};
        vecs[17] = '{OP_RNG,   16'd0,    16'd0,    16'hB401, 3'b000};
        vecs[18] = '{OP_SEED,  16'd0,    16'd0,    16'h0000, 3'b001};
        vecs[19] = '{OP_RNG,   16'd0,    16'd0,    16'h0001, 3'b000};

        m_lfsr = 16'h0001; m_res = '0; m_flg = '0; m_ov = 1'b0; mul_left = 0; mul_exp = '0;

        // Reset held for two edges
        reset_n   = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 4'd0, '0, '0);
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_in_ready", in_ready, 0);
        chk_on  = 1'b1;
        reset_n = 1'b1;
        tick();
        chk("rst_release_ready", in_ready, 1);

        // Table, one op per cycle with out_ready high
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_flags", i), flags, vecs[i].flg);
        end
        drive(1'b0, 4'd0, '0, '0);
        tick();

        // MUL 300*300: result registered WIDTH edges after the accept edge
        drive(1'b1, OP_MUL, 16'd300, 16'd300);
        tick();
        drive(1'b0, 4'd0, '0, '0);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            chk("mul_busy_ready", in_ready, 0);
            tick();
            n++;
        end
        chk("mul_latency", n, W);
        chk("mul300_result", result, 16'h5F90);
        chk("mul300_flags", flags, 3'b100);
        tick();

        // MUL 7*6
        drive(1'b1, OP_MUL, 16'd7, 16'd6);
        tick();
        drive(1'b0, 4'd0, '0, '0);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("mul7x6_latency", n, W);
        chk("mul7x6_result", result, 16'd42);
        chk("mul7x6_flags", flags, 3'b000);
        tick();

        // Reset in the middle of a multiply: nothing may come out
        drive(1'b1, OP_MUL, 16'd3, 16'd3);
        tick();
        drive(1'b0, 4'd0, '0, '0);
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("abort_no_valid", out_valid, 0);
            tick();
        end
        chk("abort_idle_ready", in_ready, 1);

        // Backpressure: result held while out_ready is low, queued op enters on release
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 16'd2, 16'd3);
        tick();
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_result", result, 16'd5);
        drive(1'b1, OP_ADD, 16'd10, 16'd20);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_result", result, 16'd5);
            chk("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", result, 16'd30);
        drive(1'b0, 4'd0, '0, '0);
        tick();

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ra, rb);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, 4'd0, '0, '0);
        out_ready = 1'b1;
        n = 0;
        while ((m_ov || mul_left > 0) && n < 40) begin
            tick();
            n++;
        end
        chk("drain_done", (m_ov || mul_left > 0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
